// File: rtl/lu_vector_sequencer.sv
// Self-test sequencer: sweeps all 16 {x,y,e1,e0} vectors into the 4:1 logic
// unit, captures w per vector and compares the word against a signature.
module lu_vector_sequencer #(
   parameter int unsigned HOLD   = 1,
   parameter logic [15:0] EXPECT = 16'h655A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        ready,
   input  logic        w,
   output logic        x,
   output logic        y,
   output logic        e1,
   output logic        e0,
   output logic        valid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] result
);

   localparam int unsigned IDX_W   = 4;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned RES_W   = 16;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(15);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic               pass_q, pass_d;
   logic [IDX_W-1:0]   vec_q, vec_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // State register and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         hold_cnt_q <= '0;
         result_q   <= '0;
         pass_q     <= 1'b0;
         vec_q      <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         hold_cnt_q <= hold_cnt_d;
         result_q   <= result_d;
         pass_q     <= pass_d;
         vec_q      <= vec_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next state, sweep bookkeeping and next-cycle output values.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_cnt_d = hold_cnt_q;
      result_d   = result_q;
      pass_d     = pass_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               result_d = '0;
               pass_d   = 1'b0;
               idx_d    = '0;
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            if (ready) begin
               hold_cnt_d = '0;
               state_d    = SETTLE;
            end
         end
         SETTLE: begin
            hold_cnt_d = CNT_W'(hold_cnt_q + CNT_W'(1));
            // w is only trusted on the last settle cycle
            if (hold_cnt_q == HOLD_LAST) begin
               result_d[idx_q] = w;
               if (idx_q == IDX_LAST) begin
                  pass_d  = ({w, result_q[14:0]} == EXPECT);
                  state_d = DONE;
               end else begin
                  idx_d   = IDX_W'(idx_q + IDX_W'(1));
                  state_d = DRIVE;
               end
            end
         end
         DONE: begin
            idx_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      vec_d   = idx_d;
      valid_d = (state_d == DRIVE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

   assign x      = vec_q[3];
   assign y      = vec_q[2];
   assign e1     = vec_q[1];
   assign e0     = vec_q[0];
   assign valid  = valid_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign pass   = pass_q;
   assign result = result_q;

endmodule
